// File: rtl/uart_pkg.sv
// Shared definitions for the UART MMIO front end: register map, CTRL/STATUS bit
// positions, TX drain FSM encoding and the count saturation helper.
package uart_pkg;

    typedef enum logic [1:0] {
        ADDR_CTRL   = 2'd0,
        ADDR_STATUS = 2'd1,
        ADDR_TXDATA = 2'd2,
        ADDR_RXDATA = 2'd3
    } reg_addr_t;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE_RX   = 2;
    localparam int CTRL_IE_TX   = 3;
    localparam int CTRL_BR_LSB  = 4;
    localparam int CTRL_CLK_LSB = 8;

    localparam int ST_TX_BUSY    = 0;
    localparam int ST_RXNE       = 1;
    localparam int ST_TX_FULL    = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_RX_OVF     = 4;
    localparam int ST_TX_OVF     = 5;
    localparam int ST_TX_CNT_LSB = 8;
    localparam int ST_RX_CNT_LSB = 12;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_REQ  = 2'd1,
        TX_BUSY = 2'd2,
        TX_GAP  = 2'd3
    } tx_state_t;

    // Mirrors the CTRL register layout bit for bit; rsvd occupies bit 1 and reads 0.
    typedef struct packed {
        logic [7:0] clk_dec;
        logic [3:0] br;
        logic       ie_tx;
        logic       ie_rx;
        logic       rsvd;
        logic       en;
    } ctrl_t;

    function automatic logic [3:0] sat4(input logic [31:0] v);
        return (v > 32'd15) ? 4'd15 : v[3:0];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through dout and synchronous flush.
// Caller must not push when full unless it pops in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;

    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = (wptr == rptr);
    assign count = wptr - rptr;
    assign dout  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage is not reset; empty gating upstream hides stale contents.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_mmio_fifo.sv
// CPU register/FIFO front end for the UART core: buffers TX bytes, drives the
// start-transmit handshake, captures RX bytes on the rxne rising edge, raises irq.
module uart_mmio_fifo
    import uart_pkg::*;
#(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cs,
    input  logic        i_we,
    input  logic        i_re,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_irq,
    output logic        o_uart_en,
    output logic        o_uart_str_tx,
    output logic [7:0]  o_uart_data_tx,
    output logic [3:0]  o_uart_br,
    output logic [7:0]  o_uart_clk_dec,
    input  logic        i_uart_busy_tx,
    input  logic        i_uart_rxne,
    input  logic [7:0]  i_uart_data_rx
);
    localparam int TXC = $clog2(TX_DEPTH) + 1;
    localparam int RXC = $clog2(RX_DEPTH) + 1;

    ctrl_t       ctrl;
    logic        rx_ovf;
    logic        tx_ovf;
    logic        rxne_q;
    logic        irq_q;
    tx_state_t   tx_state;
    logic        str_tx;
    logic [7:0]  data_tx;

    logic        wr_ctrl, wr_status, wr_txdata, rd_rxdata;
    logic        flush;
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic        rx_push, rx_pop, rx_full, rx_empty, rx_edge;
    logic [7:0]  tx_dout, rx_dout;
    logic [TXC-1:0] tx_count;
    logic [RXC-1:0] rx_count;
    logic        tx_busy;
    logic [31:0] status;
    logic        unused_wdata;

    assign unused_wdata = ^i_wdata[31:16];

    assign wr_ctrl   = i_cs & i_we & (i_addr == ADDR_CTRL);
    assign wr_status = i_cs & i_we & (i_addr == ADDR_STATUS);
    assign wr_txdata = i_cs & i_we & (i_addr == ADDR_TXDATA);
    assign rd_rxdata = i_cs & i_re & (i_addr == ADDR_RXDATA);

    // Flush while disabled and also on the very edge EN is written to 0.
    assign flush = !ctrl.en | (wr_ctrl & !i_wdata[CTRL_EN]);

    assign tx_push = wr_txdata & !tx_full;
    assign tx_pop  = (tx_state == TX_IDLE) & !tx_empty & !i_uart_busy_tx & !flush;

    assign rx_edge = i_uart_rxne & !rxne_q;
    assign rx_pop  = rd_rxdata & !rx_empty;
    assign rx_push = rx_edge & (!rx_full | rx_pop);

    assign tx_busy = !tx_empty | (tx_state != TX_IDLE);

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (i_clk),
        .rst_n (i_rst),
        .flush (flush),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (i_wdata[7:0]),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (i_clk),
        .rst_n (i_rst),
        .flush (flush),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (i_uart_data_rx),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ctrl   <= '0;
            rx_ovf <= 1'b0;
            tx_ovf <= 1'b0;
            rxne_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            rxne_q <= i_uart_rxne;
            irq_q  <= (ctrl.ie_rx & !rx_empty) | (ctrl.ie_tx & !tx_busy);
            if (wr_ctrl) begin
                ctrl.en      <= i_wdata[CTRL_EN];
                ctrl.rsvd    <= 1'b0;
                ctrl.ie_rx   <= i_wdata[CTRL_IE_RX];
                ctrl.ie_tx   <= i_wdata[CTRL_IE_TX];
                ctrl.br      <= i_wdata[CTRL_BR_LSB +: 4];
                ctrl.clk_dec <= i_wdata[CTRL_CLK_LSB +: 8];
            end
            // A new overflow in the same cycle as a W1C wins over the clear.
            if (rx_edge & rx_full & !rx_pop & !flush)
                rx_ovf <= 1'b1;
            else if (wr_status & i_wdata[ST_RX_OVF])
                rx_ovf <= 1'b0;
            if (wr_txdata & tx_full & !flush)
                tx_ovf <= 1'b1;
            else if (wr_status & i_wdata[ST_TX_OVF])
                tx_ovf <= 1'b0;
        end
    end

    // data_tx is only loaded in IDLE, so it stays stable through REQ and BUSY.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tx_state <= TX_IDLE;
            str_tx   <= 1'b0;
            data_tx  <= 8'h00;
        end else if (flush) begin
            tx_state <= TX_IDLE;
            str_tx   <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        data_tx  <= tx_dout;
                        str_tx   <= 1'b1;
                        tx_state <= TX_REQ;
                    end
                end
                TX_REQ: begin
                    if (i_uart_busy_tx) begin
                        str_tx   <= 1'b0;
                        tx_state <= TX_BUSY;
                    end
                end
                TX_BUSY: begin
                    if (!i_uart_busy_tx) tx_state <= TX_GAP;
                end
                TX_GAP: begin
                    tx_state <= TX_IDLE;
                end
                default: begin
                    str_tx   <= 1'b0;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        status = '0;
        status[ST_TX_BUSY] = tx_busy;
        status[ST_RXNE]    = !rx_empty;
        status[ST_TX_FULL] = tx_full;
        status[ST_RX_FULL] = rx_full;
        status[ST_RX_OVF]  = rx_ovf;
        status[ST_TX_OVF]  = tx_ovf;
        status[ST_TX_CNT_LSB +: 4] = sat4(32'(tx_count));
        status[ST_RX_CNT_LSB +: 4] = sat4(32'(rx_count));
    end

    always_comb begin
        o_rdata = '0;
        if (i_cs & i_re) begin
            case (reg_addr_t'(i_addr))
                ADDR_CTRL:   o_rdata = {16'h0000, ctrl};
                ADDR_STATUS: o_rdata = status;
                ADDR_RXDATA: o_rdata = rx_empty ? 32'h0 : {24'h0, rx_dout};
                default:     o_rdata = '0;
            endcase
        end
    end

    assign o_irq          = irq_q;
    assign o_uart_en      = ctrl.en;
    assign o_uart_str_tx  = str_tx;
    assign o_uart_data_tx = data_tx;
    assign o_uart_br      = ctrl.br;
    assign o_uart_clk_dec = ctrl.clk_dec;

endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed bench for uart_mmio_fifo with a behavioural UART (TX optionally looped to RX);
// expected TX bytes and register reads are queued and checked by independent monitors.
module tb_uart_mmio_fifo;
    import uart_pkg::*;

    localparam int FRAME = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0, we = 1'b0, re = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        irq, uart_en, str_tx;
    logic [7:0]  data_tx, clk_dec;
    logic [3:0]  br;
    logic        busy_tx = 1'b0;
    logic        rxne;
    logic [7:0]  data_rx;

    logic        m_rxne = 1'b0, t_rxne = 1'b0;
    logic [7:0]  m_rx = 8'h0, t_rx = 8'h0;
    bit          loop_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  tx_exp[$];
    logic [31:0] rd_exp[$];
    string       rd_name[$];

    assign rxne    = m_rxne | t_rxne;
    assign data_rx = m_rxne ? m_rx : t_rx;

    always #5 clk = ~clk;

    uart_mmio_fifo #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_cs           (cs),
        .i_we           (we),
        .i_re           (re),
        .i_addr         (addr),
        .i_wdata        (wdata),
        .o_rdata        (rdata),
        .o_irq          (irq),
        .o_uart_en      (uart_en),
        .o_uart_str_tx  (str_tx),
        .o_uart_data_tx (data_tx),
        .o_uart_br      (br),
        .o_uart_clk_dec (clk_dec),
        .i_uart_busy_tx (busy_tx),
        .i_uart_rxne    (rxne),
        .i_uart_data_rx (data_rx)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Register read monitor: compares o_rdata mid-cycle whenever a read is on the bus.
    always @(negedge clk) begin
        if (rst_n && cs && re) begin
            if (rd_exp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: got 0x%0h, expected no read", rdata);
            end else begin
                check(rd_name.pop_front(), rdata, rd_exp.pop_front());
            end
        end
    end

    // Behavioural UART: accepts str_tx, stays busy for a frame, optionally loops the byte back.
    logic [7:0] cur_byte = 8'h0;
    int         frame_cnt = 0;
    int         m_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            busy_tx = 1'b0;
            m_rxne  = 1'b0;
            m_cnt   = 0;
        end else begin
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) m_rxne = 1'b0;
            end
            if (busy_tx) begin
                if (!uart_en) begin
                    busy_tx = 1'b0;
                end else if (frame_cnt == 0) begin
                    busy_tx = 1'b0;
                    check("tx_data_stable", {24'h0, data_tx}, {24'h0, cur_byte});
                    if (loop_en) begin
                        m_rx   = cur_byte;
                        m_rxne = 1'b1;
                        m_cnt  = 2;
                    end
                end else begin
                    frame_cnt--;
                end
            end else if (str_tx && uart_en) begin
                busy_tx   = 1'b1;
                frame_cnt = FRAME;
                cur_byte  = data_tx;
                if (tx_exp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got 0x%0h, expected no byte", data_tx);
                end else begin
                    check("tx_byte", {24'h0, data_tx}, {24'h0, tx_exp.pop_front()});
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; we = 1'b1; re = 1'b0; addr = a; wdata = d;
        @(posedge clk);
        #1;
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        rd_exp.push_back(exp);
        rd_name.push_back(name);
        cs = 1'b1; re = 1'b1; we = 1'b0; addr = a;
        @(posedge clk);
        #1;
        cs = 1'b0; re = 1'b0;
    endtask

    task automatic rx_byte(input logic [7:0] d);
        t_rx = d;
        t_rxne = 1'b1;
        cycles(2);
        t_rxne = 1'b0;
        cycles(2);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((tx_exp.size() != 0 || busy_tx || m_rxne || str_tx) && k < 3000) begin
            cycles(1);
            k++;
        end
        cycles(4);
        check(name, {31'h0, (k < 3000)}, 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cycles(3);
        check("reset_outputs", {irq, uart_en, str_tx, data_tx, br, clk_dec}, 32'h0);
        rst_n = 1'b1;
        cycles(2);
        bus_read(ADDR_STATUS, 32'h0, "reset_status");
        bus_read(ADDR_RXDATA, 32'h0, "reset_rxdata_empty");

        // Basic config and loopback transfer of two bytes.
        bus_write(ADDR_CTRL, 32'h1B01);
        bus_read(ADDR_CTRL, 32'h1B01, "ctrl_readback");
        check("clk_dec_out", {24'h0, clk_dec}, 32'h1B);
        check("en_out", {31'h0, uart_en}, 32'h1);
        loop_en = 1'b1;
        tx_exp.push_back(8'h55);
        tx_exp.push_back(8'hA3);
        bus_write(ADDR_TXDATA, 32'h55);
        bus_write(ADDR_TXDATA, 32'hA3);
        bus_read(ADDR_TXDATA, 32'h0, "txdata_reads_zero");
        wait_idle("loop_timeout");
        bus_read(ADDR_STATUS, 32'h2002, "status_rx2");
        bus_read(ADDR_RXDATA, 32'h55, "rx_loop_0");
        bus_read(ADDR_RXDATA, 32'hA3, "rx_loop_1");
        bus_read(ADDR_STATUS, 32'h0, "status_drained");
        loop_en = 1'b0;

        // 10 back-to-back writes: first popped immediately, 8 queued, last dropped.
        for (int i = 0; i < 9; i++) tx_exp.push_back(8'h10 + 8'(i));
        for (int i = 0; i < 10; i++) bus_write(ADDR_TXDATA, 32'h10 + i);
        bus_read(ADDR_STATUS, 32'h825, "status_tx_ovf");
        bus_write(ADDR_STATUS, 32'h20);
        bus_read(ADDR_STATUS, 32'h805, "status_tx_ovf_clr");
        wait_idle("burst_timeout");
        bus_read(ADDR_STATUS, 32'h0, "status_after_burst");

        // RX overflow, then simultaneous pop+push on a full FIFO.
        for (int i = 0; i < 9; i++) rx_byte(8'h80 + 8'(i));
        bus_read(ADDR_STATUS, 32'h801A, "status_rx_ovf");
        bus_write(ADDR_STATUS, 32'h10);
        fork
            rx_byte(8'h90);
            bus_read(ADDR_RXDATA, 32'h80, "rx_ovf_0");
        join
        bus_read(ADDR_STATUS, 32'h800A, "status_full_poppush");
        for (int i = 1; i < 8; i++) bus_read(ADDR_RXDATA, 32'h80 + i, "rx_ovf_n");
        bus_read(ADDR_RXDATA, 32'h90, "rx_after_poppush");
        bus_read(ADDR_STATUS, 32'h0, "status_rx_drained");

        // Two-cycle rxne yields exactly one push.
        rx_byte(8'h3C);
        bus_read(ADDR_STATUS, 32'h1002, "status_one_push");
        bus_read(ADDR_RXDATA, 32'h3C, "rx_single");

        // RX interrupt.
        bus_write(ADDR_CTRL, 32'h1B05);
        cycles(2);
        check("irq_rx_idle", {31'h0, irq}, 32'h0);
        rx_byte(8'h42);
        check("irq_rx_set", {31'h0, irq}, 32'h1);
        bus_read(ADDR_RXDATA, 32'h42, "rx_irq_byte");
        cycles(2);
        check("irq_rx_clr", {31'h0, irq}, 32'h0);

        // Disable mid-frame with 3 bytes queued.
        bus_write(ADDR_CTRL, 32'h1B09);
        cycles(2);
        check("irq_tx_idle", {31'h0, irq}, 32'h1);
        tx_exp.push_back(8'h01);
        for (int i = 1; i <= 4; i++) bus_write(ADDR_TXDATA, i);
        cycles(5);
        check("irq_tx_busy", {31'h0, irq}, 32'h0);
        bus_write(ADDR_CTRL, 32'h1B08);
        bus_read(ADDR_STATUS, 32'h0, "status_after_disable");
        check("irq_after_disable", {31'h0, irq}, 32'h1);
        check("str_tx_after_disable", {31'h0, str_tx}, 32'h0);

        // Asynchronous reset in the middle of a frame.
        bus_write(ADDR_CTRL, 32'h1BF5);
        rx_byte(8'h99);
        tx_exp.push_back(8'h77);
        bus_write(ADDR_TXDATA, 32'h77);
        cycles(4);
        check("pre_reset_outputs", {irq, uart_en, data_tx, br, clk_dec}, {1'b1, 1'b1, 8'h77, 4'hF, 8'h1B});
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {irq, uart_en, str_tx, data_tx, br, clk_dec}, 32'h0);
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
        bus_read(ADDR_STATUS, 32'h0, "status_after_reset");
        bus_read(ADDR_RXDATA, 32'h0, "rxdata_after_reset");
        bus_read(ADDR_CTRL, 32'h0, "ctrl_after_reset");

        cycles(2);
        check("tx_exp_left", tx_exp.size(), 32'h0);
        check("rd_exp_left", rd_exp.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
